// File: rtl/uart_rx_ctrl.sv
// Purpose: owns UART receiver config (PAR_EN/PAR_TYPE/prescale), applies host writes at frame end or line idle, and buffers received bytes in a FWFT FIFO.
// Latency: config applied on the edge where data_valid or line_idle is seen while pending; cfg_ack/cfg_err one cycle after the cause; FIFO head visible one cycle after push.
// Backpressure: none toward the receiver; a push into a full FIFO without a simultaneous pop drops the byte and sets sticky ovf.
module uart_rx_ctrl #(
  parameter int DEPTH        = 8,
  parameter int IDLE_BITS    = 11,
  parameter int RST_PRESCALE = 8,
  parameter bit RST_PAR_EN   = 1'b1,
  parameter bit RST_PAR_TYPE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RX_IN,
  input  logic                     data_valid,
  input  logic [7:0]               P_Data,
  input  logic                     cfg_wr,
  input  logic [4:0]               cfg_prescale,
  input  logic                     cfg_par_en,
  input  logic                     cfg_par_type,
  output logic                     cfg_ack,
  output logic                     cfg_err,
  output logic                     PAR_EN,
  output logic                     PAR_TYPE,
  output logic [4:0]               prescale,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0] prescale;
    logic       par_en;
    logic       par_type;
  } cfg_t;

  localparam cfg_t RST_CFG = '{prescale: 5'(RST_PRESCALE), par_en: RST_PAR_EN, par_type: RST_PAR_TYPE};

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t     state_q, state_d;
  cfg_t       cfg_in, pend_q, active_q;
  logic       cfg_legal, wr_ok, wr_bad;
  logic       apply, capture;
  logic [8:0] idle_cnt, idle_thresh;
  logic       line_idle;

  assign cfg_in    = '{prescale: cfg_prescale, par_en: cfg_par_en, par_type: cfg_par_type};
  assign cfg_legal = (cfg_prescale == 5'd8) || (cfg_prescale == 5'd16);
  assign wr_ok     = cfg_wr && cfg_legal;
  assign wr_bad    = cfg_wr && !cfg_legal;

  assign PAR_EN   = active_q.par_en;
  assign PAR_TYPE = active_q.par_type;
  assign prescale = active_q.prescale;

  // Threshold follows the active prescale; 11*16 = 176 fits in 9 bits.
  assign idle_thresh = 9'(IDLE_BITS) * {4'd0, active_q.prescale};
  assign line_idle   = (idle_cnt >= idle_thresh);

  // Idle counter: cleared by any low bit on the line, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                idle_cnt <= '0;
    else if (!RX_IN)         idle_cnt <= '0;
    else if (idle_cnt != '1) idle_cnt <= idle_cnt + 9'd1;
  end

  // Config FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state: a legal write always (re)arms PENDING, even on the apply edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (wr_ok) state_d = S_PEND;
      S_PEND: begin
        if (wr_ok)                          state_d = S_PEND;
        else if (data_valid || line_idle)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: apply the pending triple at a frame boundary or idle line.
  always_comb begin
    apply   = 1'b0;
    capture = wr_ok;
    if (state_q == S_PEND && (data_valid || line_idle)) apply = 1'b1;
  end

  // Pending/active config registers and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= RST_CFG;
      active_q <= RST_CFG;
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (apply)   active_q <= pend_q;
      if (capture) pend_q   <= cfg_in;
      cfg_ack <= apply;
      cfg_err <= wr_bad;
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, drop, push;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign fifo_count = count;
  assign rd_data    = mem[rd_ptr];

  assign pop  = rd_en && !empty;
  assign drop = data_valid && full && !pop;
  assign push = data_valid && !drop;

  // Storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= P_Data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Purpose: directed plus randomized check of uart_rx_ctrl against a queue-based reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench drives one-cycle strobes; model decides drop/ovf from queue occupancy.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1, dv = 1'b0, wr = 1'b0, rd = 1'b0, oclr = 1'b0;
  logic [7:0] pd = '0;
  logic [4:0] wps = '0;
  logic       wpe = 1'b0, wpt = 1'b0;
  logic       cfg_ack, cfg_err, PAR_EN, PAR_TYPE, empty, full, ovf;
  logic [4:0] prescale;
  logic [7:0] rd_data;
  logic [3:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst_n), .RX_IN(rx), .data_valid(dv), .P_Data(pd),
    .cfg_wr(wr), .cfg_prescale(wps), .cfg_par_en(wpe), .cfg_par_type(wpt),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .PAR_EN(PAR_EN), .PAR_TYPE(PAR_TYPE),
    .prescale(prescale), .rd_en(rd), .rd_data(rd_data), .empty(empty), .full(full),
    .fifo_count(fifo_count), .ovf(ovf), .ovf_clr(oclr)
  );

  always #5 clk = ~clk;

  // Reference model: active/pending config, idle run length, byte queue.
  int  m_ps, p_ps, m_run;
  bit  m_pe, m_pt, p_pe, p_pt, m_pv, m_ovf, m_ack, m_err;
  byte unsigned q[$];

  task automatic m_reset();
    m_ps = 8; m_pe = 1; m_pt = 0;
    m_pv = 0; p_ps = 8; p_pe = 1; p_pt = 0;
    m_run = 0; m_ovf = 0; m_ack = 0; m_err = 0;
    q.delete();
  endtask

  task automatic m_step();
    bit legal, idle, app, do_pop, do_drop;
    legal = (int'(wps) == 8) || (int'(wps) == 16);
    idle  = (m_run >= 11 * m_ps);
    app   = m_pv && (dv || idle);
    m_ack = app;
    m_err = wr && !legal;
    if (app) begin m_ps = p_ps; m_pe = p_pe; m_pt = p_pt; end
    if (wr && legal) begin m_pv = 1; p_ps = int'(wps); p_pe = wpe; p_pt = wpt; end
    else if (app) m_pv = 0;
    m_run = rx ? ((m_run < 511) ? m_run + 1 : 511) : 0;
    do_pop  = rd && (q.size() > 0);
    do_drop = dv && (q.size() == DEPTH) && !do_pop;
    if (do_pop) void'(q.pop_front());
    if (dv && !do_drop) q.push_back(pd);
    if (do_drop) m_ovf = 1;
    else if (oclr) m_ovf = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("prescale", 32'(prescale), 32'(m_ps));
    chk("par_en", 32'(PAR_EN), 32'(m_pe));
    chk("par_type", 32'(PAR_TYPE), 32'(m_pt));
    chk("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (q.size() > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
  endtask

  // One clock: model steps on the edge, outputs checked 1 unit later, strobes dropped.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) m_reset(); else m_step();
    #1;
    check_all();
    dv = 0; wr = 0; rd = 0; oclr = 0;
  endtask

  task automatic cfg(input int ps, input bit pe, input bit pt);
    wr = 1; wps = 5'(ps); wpe = pe; wpt = pt;
  endtask

  initial begin
    byte unsigned x;
    m_reset();
    // 1: reset defaults
    repeat (3) cyc();
    rst_n = 1;
    repeat (5) cyc();
    chk("t1_prescale", 32'(prescale), 8);
    chk("t1_par_en", 32'(PAR_EN), 1);
    chk("t1_par_type", 32'(PAR_TYPE), 0);
    chk("t1_empty", 32'(empty), 1);
    chk("t1_count", 32'(fifo_count), 0);
    chk("t1_ovf", 32'(ovf), 0);

    // Idle apply: threshold 11*8 = 88 consecutive high cycles
    rx = 0; cyc();
    rx = 1; cfg(16, 1, 1); cyc();
    repeat (87) cyc();
    chk("t3_before_ps", 32'(prescale), 8);
    chk("t3_before_ack", 32'(cfg_ack), 0);
    cyc();
    chk("t3_apply_ps", 32'(prescale), 16);
    chk("t3_apply_ack", 32'(cfg_ack), 1);
    // Illegal prescale
    cfg(12, 0, 0); cyc();
    chk("t3_err", 32'(cfg_err), 1);
    chk("t3_err_noack", 32'(cfg_ack), 0);
    chk("t3_err_ps", 32'(prescale), 16);
    cyc();
    chk("t3_err_once", 32'(cfg_err), 0);

    // 2: frame active, apply only at data_valid
    rx = 0; cyc();
    cfg(8, 0, 0); cyc();
    repeat (20) cyc();
    chk("t2_hold_pe", 32'(PAR_EN), 1);
    chk("t2_hold_ps", 32'(prescale), 16);
    dv = 1; pd = 8'($urandom); cyc();
    chk("t2_apply_pe", 32'(PAR_EN), 0);
    chk("t2_apply_ps", 32'(prescale), 8);
    chk("t2_apply_ack", 32'(cfg_ack), 1);
    cyc();
    chk("t2_ack_once", 32'(cfg_ack), 0);
    rd = 1; cyc();

    // 4: fill, overflow, ovf clear rules, drain in order
    for (int i = 1; i <= 8; i++) begin dv = 1; pd = 8'(i); cyc(); end
    chk("t4_full", 32'(full), 1);
    chk("t4_count", 32'(fifo_count), 8);
    chk("t4_head", 32'(rd_data), 1);
    dv = 1; pd = 8'h09; cyc();
    chk("t4_ovf", 32'(ovf), 1);
    chk("t4_ovf_count", 32'(fifo_count), 8);
    oclr = 1; cyc();
    chk("t4_ovf_clr", 32'(ovf), 0);
    dv = 1; pd = 8'h0A; oclr = 1; cyc();
    chk("t4_set_wins", 32'(ovf), 1);
    oclr = 1; cyc();
    for (int i = 1; i <= 8; i++) begin
      chk("t4_pop", 32'(rd_data), 32'(i));
      rd = 1; cyc();
    end
    chk("t4_empty", 32'(empty), 1);
    rd = 1; cyc();
    chk("t4_pop_empty", 32'(fifo_count), 0);
    dv = 1; rd = 1; pd = 8'h5A; cyc();
    chk("t4_push_pop_empty", 32'(fifo_count), 1);
    chk("t4_push_pop_head", 32'(rd_data), 32'h5A);
    rd = 1; cyc();

    // 5: full with push+pop, newest byte comes out last after wrap
    for (int i = 0; i < 8; i++) begin dv = 1; pd = 8'($urandom); cyc(); end
    x = 8'($urandom);
    dv = 1; rd = 1; pd = x; cyc();
    chk("t5_count", 32'(fifo_count), 8);
    chk("t5_ovf", 32'(ovf), 0);
    repeat (7) begin rd = 1; cyc(); end
    chk("t5_last", 32'(rd_data), 32'(x));
    rd = 1; cyc();
    chk("t5_empty", 32'(empty), 1);

    // Randomized traffic against the model
    for (int blk = 0; blk < 8; blk++) begin
      for (int c = 0; c < ((blk % 2) ? 200 : 50); c++) begin
        rx   = (blk % 2) ? 1'b1 : 1'($urandom);
        dv   = ($urandom_range(0, 3) == 0);
        pd   = 8'($urandom);
        rd   = ($urandom_range(0, 2) == 0);
        oclr = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 2))
            0: cfg(8, 1'($urandom), 1'($urandom));
            1: cfg(16, 1'($urandom), 1'($urandom));
            default: cfg(int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
          endcase
        end
        cyc();
      end
    end

    // 6: last write wins, then reset drops a pending write
    rx = 0; cyc();
    repeat (DEPTH + 1) begin rd = 1; cyc(); end
    dv = 1; pd = 8'h11; cyc();
    rd = 1; cyc();
    cfg(16, 1, 1); cyc();
    cfg(8, 0, 1); cyc();
    chk("t6_no_early_ack", 32'(cfg_ack), 0);
    dv = 1; pd = 8'h22; cyc();
    chk("t6_b_ps", 32'(prescale), 8);
    chk("t6_b_pe", 32'(PAR_EN), 0);
    chk("t6_b_pt", 32'(PAR_TYPE), 1);
    chk("t6_b_ack", 32'(cfg_ack), 1);
    cyc();
    chk("t6_single_ack", 32'(cfg_ack), 0);
    rd = 1; cyc();
    dv = 1; pd = 8'h33; cyc();
    cfg(16, 1, 1); cyc();
    cfg(16, 0, 0); cyc();
    repeat (3) cyc();
    rst_n = 0;
    #1;
    m_reset();
    check_all();
    chk("t6_rst_ps", 32'(prescale), 8);
    chk("t6_rst_pe", 32'(PAR_EN), 1);
    chk("t6_rst_empty", 32'(empty), 1);
    repeat (2) cyc();
    rst_n = 1;
    repeat (20) cyc();
    chk("t6_after_ps", 32'(prescale), 8);
    chk("t6_after_pe", 32'(PAR_EN), 1);
    chk("t6_after_ack", 32'(cfg_ack), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
